// File: rtl/pixel_stream_tx.sv
// pixel_stream_tx: host-side feeder for the MNIST inference core.
// Accepts 8-pixel binary bytes, streams them 1 bit/cycle (MSB first) onto the
// core's serial pixel input, then waits for the 4-bit prediction and returns it.
// Optional feature macro: MNIST_PRED_CHECK_EN (reject predictions above 9).
// Handshakes: a byte moves when byte_valid & byte_ready are both high at a
// rising clk edge; byte_ready never depends on byte_valid. data_out is only
// meaningful while data_out_valid is high (no backpressure from the core).
module pixel_stream_tx #(
    parameter int IMG_W       = 28,
    parameter int IMG_H       = 28,
    parameter int RES_TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       data_out,
    output logic       data_out_valid,
    output logic       sof,
    output logic       eof,
    input  logic [3:0] pred_in,
    input  logic       pred_valid_in,
    output logic [3:0] result,
    output logic       result_valid,
    output logic       timeout_err,
    output logic       pred_err
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int PW   = $clog2(NPIX);
    localparam int TW   = $clog2(RES_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        WAIT_RES = 2'd2
    } state_t;

    // state is kept as a named enum so checkers can bind to it directly
    state_t        state;
    state_t        state_nxt;
    logic [7:0]    shreg;
    logic [3:0]    bit_cnt;     // bits still held in shreg (0..8)
    logic [PW-1:0] pix_cnt;     // pixels already emitted in this frame
    logic [TW-1:0] tmo_cnt;
    logic [PW:0]   queued;      // pixels emitted plus pixels buffered
    logic          more_bytes;
    logic          pix_valid;
    logic          last_pix;
    logic          accept;
    logic          pred_ok;
    logic          tmo_hit;

    assign queued     = {1'b0, pix_cnt} + (PW+1)'(bit_cnt);
    assign more_bytes = queued < (PW+1)'(NPIX);
    assign pix_valid  = (state == SHIFT) && (bit_cnt != 4'd0);
    assign last_pix   = pix_valid && (pix_cnt == PW'(NPIX - 1));
    assign accept     = byte_valid && byte_ready;
    assign tmo_hit    = (state == WAIT_RES) && !pred_valid_in &&
                        (tmo_cnt == TW'(RES_TIMEOUT - 1));

`ifdef MNIST_PRED_CHECK_EN
    assign pred_ok = (pred_in <= 4'd9);
`else
    assign pred_ok = 1'b1;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: one frame in flight, then wait for the core's answer
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (accept) state_nxt = SHIFT;
            SHIFT:    if (last_pix) state_nxt = WAIT_RES;
            WAIT_RES: if (pred_valid_in || tmo_hit) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Outputs: ready on the 8th bit allows a gap-free stream; ready is held
    // low while reset is asserted so every output reads 0 during reset
    always_comb begin
        byte_ready     = 1'b0;
        data_out       = 1'b0;
        data_out_valid = pix_valid;
        sof            = pix_valid && (pix_cnt == '0);
        eof            = last_pix;
        if (pix_valid) data_out = shreg[7];
        case (state)
            IDLE:    byte_ready = rst_n;
            SHIFT:   byte_ready = rst_n && (bit_cnt <= 4'd1) && more_bytes;
            default: byte_ready = 1'b0;
        endcase
    end

    // Datapath: shift register, counters, result latch and status pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg        <= '0;
            bit_cnt      <= '0;
            pix_cnt      <= '0;
            tmo_cnt      <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            timeout_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg   <= byte_in;
                        bit_cnt <= 4'd8;
                        pix_cnt <= '0;
                    end
                end
                SHIFT: begin
                    // a reload on the 8th bit overrides the shift of that bit
                    if (accept) begin
                        shreg   <= byte_in;
                        bit_cnt <= 4'd8;
                    end else if (pix_valid) begin
                        shreg   <= {shreg[6:0], 1'b0};
                        bit_cnt <= bit_cnt - 4'd1;
                    end
                    if (pix_valid && !last_pix) pix_cnt <= pix_cnt + PW'(1);
                    if (last_pix) tmo_cnt <= '0;
                end
                WAIT_RES: begin
                    if (tmo_cnt != TW'(RES_TIMEOUT - 1)) tmo_cnt <= tmo_cnt + TW'(1);
                    if (pred_valid_in && pred_ok) begin
                        result       <= pred_in;
                        result_valid <= 1'b1;
                    end
                    if (tmo_hit) timeout_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef MNIST_PRED_CHECK_EN
    // Out-of-range prediction: flag it and leave result untouched
    always_ff @(posedge clk) begin
        if (!rst_n) pred_err <= 1'b0;
        else        pred_err <= (state == WAIT_RES) && pred_valid_in && !pred_ok;
    end
`else
    assign pred_err = 1'b0;
`endif

endmodule
